// File: rtl/aim_pkg.sv
// ---------------------------------------------------------------------------
// aim_pkg
// Shared definitions for the AI-core command scheduler:
//   aim_state_e      - scheduler FSM states
//   AIM_TIMEOUT_DEF  - default number of cycles the core gets to answer
//   aim_sat_inc8     - saturating 8-bit increment used by event counters
// ---------------------------------------------------------------------------
package aim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } aim_state_e;

  localparam int AIM_TIMEOUT_DEF = 1024;

  function automatic logic [7:0] aim_sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/aim_rr_arbiter.sv
// ---------------------------------------------------------------------------
// aim_rr_arbiter
// Combinational round-robin grant: searches i_req starting at index i_ptr,
// moving upward and wrapping, and grants the first asserted request.
// Ports:
//   i_req   [NUM_REQ-1:0]          request vector
//   i_ptr   [$clog2(NUM_REQ)-1:0]  highest-priority index this cycle
//   o_grant [NUM_REQ-1:0]          one-hot grant (all zero when no request)
// ---------------------------------------------------------------------------
module aim_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_grant
);

  logic w_found;

  // k is the search distance from i_ptr; only index i matching that
  // distance is considered, so all selects stay constant-indexed.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && (i == ((int'(i_ptr) + k) % NUM_REQ)) && i_req[i]) begin
          o_grant[i] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aim_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// aim_cmd_scheduler
// Accepts commands from NUM_REQ requesters (round-robin), launches the AI
// core with one start pulse, waits for its result or a timeout, and returns
// a single tagged response. One command is in flight at a time.
// Ports:
//   clk, reset                 clock / asynchronous active-high reset
//   req_valid/req_ready        per-requester command handshake
//   req_instr/req_data         per-requester 32-bit words, packed 32*i
//   core_start                 one-cycle launch pulse
//   core_instr/core_data       latched command for the core
//   core_result(_valid)        core answer and strobe
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/rsp_result/rsp_err  owner index, result (0 on timeout), timeout flag
//   busy                       high whenever not IDLE
//   timeout_count              saturating number of timeouts
// ---------------------------------------------------------------------------
module aim_cmd_scheduler
  import aim_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = AIM_TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*32-1:0]      req_instr,
  input  logic [NUM_REQ*32-1:0]      req_data,
  output logic                       core_start,
  output logic [31:0]                core_instr,
  output logic [31:0]                core_data,
  input  logic [31:0]                core_result,
  input  logic                       core_result_valid,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [31:0]                rsp_result,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [7:0]                 timeout_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  aim_state_e      r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_owner;
  logic [CW-1:0]   r_tmo_cnt;
  logic            r_core_start;
  logic [31:0]     r_core_instr;
  logic [31:0]     r_core_data;
  logic            r_rsp_valid;
  logic [IW-1:0]   r_rsp_id;
  logic [31:0]     r_rsp_result;
  logic            r_rsp_err;
  logic [7:0]      r_tmo_total;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_hs;
  logic [IW-1:0]      w_gidx;
  logic [IW-1:0]      w_next_ptr;
  logic [31:0]        w_instr;
  logic [31:0]        w_data;

  aim_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  // Grant is only offered while IDLE; everyone else stalls.
  assign w_req_ready = (r_state == IDLE) ? w_grant : '0;
  assign w_hs        = |(req_valid & w_req_ready);

  // Decode the one-hot grant into an index and select that requester's words.
  always_comb begin
    w_gidx  = '0;
    w_instr = '0;
    w_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gidx  = IW'(i);
        w_instr = req_instr[32*i +: 32];
        w_data  = req_data[32*i +: 32];
      end
    end
  end

  assign w_next_ptr = (w_gidx == IW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_tmo_cnt    <= '0;
      r_core_start <= 1'b0;
      r_core_instr <= '0;
      r_core_data  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
      r_tmo_total  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_core_instr <= w_instr;
            r_core_data  <= w_data;
            r_owner      <= w_gidx;
            r_rr_ptr     <= w_next_ptr;
            r_core_start <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_core_start <= 1'b0;
          r_tmo_cnt    <= '0;
          r_state      <= WAIT;
        end
        WAIT: begin
          // A result arriving in the timeout cycle wins over the timeout.
          if (core_result_valid) begin
            r_rsp_result <= core_result;
            r_rsp_err    <= 1'b0;
            r_rsp_id     <= r_owner;
            r_rsp_valid  <= 1'b1;
            r_state      <= RESP;
          end else if (r_tmo_cnt == CW'(TIMEOUT - 1)) begin
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b1;
            r_rsp_id     <= r_owner;
            r_rsp_valid  <= 1'b1;
            r_tmo_total  <= aim_sat_inc8(r_tmo_total);
            r_state      <= RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready     = w_req_ready;
  assign core_start    = r_core_start;
  assign core_instr    = r_core_instr;
  assign core_data     = r_core_data;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_id        = r_rsp_id;
  assign rsp_result    = r_rsp_result;
  assign rsp_err       = r_rsp_err;
  assign busy          = (r_state != IDLE);
  assign timeout_count = r_tmo_total;

endmodule
